byte_packer: RTL
================

# byte_packer

Upstream feeder for the 4-entry, 64-bit `fifo`. It accepts a stream of 8-bit bytes and packs each group of eight, most-significant byte first, into one 64-bit word. It pushes each complete word into the FIFO through the FIFO's `data_in` / `data_in_valid` / `fifo_full` interface, and back-pressures the byte source while a finished word cannot be delivered. A `flush` input closes a partial word with zero padding.

## Interface
Parameters: none. Widths are fixed at 8-bit input and 64-bit output.

- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `byte_in`  in  8  Input byte.
- `byte_in_valid`  in  1  `byte_in` presented this cycle.
- `flush`  in  1  Close the current partial word: pad with zeros and mark it complete.
- `fifo_full`  in  1  From the FIFO's `fifo_full` output.
- `word_out`  out  64  To the FIFO's `data_in`. Equal to the packing register at all times.
- `word_out_valid`  out  1  To the FIFO's `data_in_valid`. High means a push is performed this cycle.
- `byte_in_stall`  out  1  High means a byte presented this cycle is not accepted.
- `byte_count`  out  4  Bytes currently held in the packing register, 0..8.
- `err`  out  1  Protocol-violation pulse (see Operation).

## Operation
- **State:** 64-bit packing register `W`, 4-bit count `cnt` (0..8), 1-bit registered `err`.
- **Reset values:** `W` = 0, `cnt` = 0, `err` = 0.
- **Outputs while `rst` is high:** `word_out_valid` = 0, `byte_in_stall` = 0.
- **States, derived from `cnt`:**
  - FILL: `cnt` 0..7.
  - FULL: `cnt` = 8.
- **Complete:** `complete` = (`cnt` == 8).
- **Output equations (combinational):**
  - `word_out_valid` = `complete` && !`fifo_full` && !`rst`.
  - `byte_in_stall` = `complete` && `fifo_full`.
- **Byte acceptance:** `accept` = `byte_in_valid` && !`byte_in_stall`.
- **Packing order:**
  - The byte accepted when the effective count is k goes into `W[63-8k -: 8]`.
  - The first byte of a word lands in `[63:56]`.
  - The eighth byte lands in `[7:0]`.
- **Next-state rules, evaluated in this order:**
  1. **Push.** If `word_out_valid`: the FIFO takes `W` this edge. The effective count becomes 0 and `W` is cleared to 0.
  2. **Byte.** If `accept`: write `byte_in` at the effective count, then increment the count.
  3. **Flush.** If `flush` and the count after step 2 is between 1 and 7: set `cnt` = 8. Unwritten low bytes remain 0.
     - `flush` at count 0 is a no-op.
     - `flush` while FULL is a no-op.
- **Simultaneous push and byte:** push and byte acceptance in the same cycle are legal. The outgoing word leaves and the new byte becomes byte 0 of the next word, so `cnt` = 1. This sustains one byte per cycle with no bubble while the FIFO has space.
- **Byte plus flush:** a byte accepted together with `flush` is included before padding. For example, at `cnt` = 2, byte plus flush yields 3 data bytes followed by 5 zero bytes, with `cnt` = 8.
- **FULL with FIFO full:** `W` holds, `word_out_valid` = 0, and `byte_in_stall` = 1 until `fifo_full` falls. The push happens in the first cycle `fifo_full` is low.
- **`err` conditions:** `err` is registered and goes high for exactly one cycle following any cycle with either:
  - `byte_in_valid` && `byte_in_stall` (the byte is dropped and `W` is unchanged), or
  - `flush` && `byte_in_stall`.
  - `err` never holds beyond one cycle unless the violation repeats.
- **Reset mid-word:** discards the partial or complete word. No push occurs in the reset cycle. `cnt` = 0 after the edge.

## Timing
- **Latency:** the eighth byte is accepted at edge N. `word_out_valid` can be high in cycle N+1, and the push completes at edge N+1.
- **Throughput:** 1 byte per cycle, i.e. one word every 8 cycles, when `fifo_full` stays low.
- **Push qualification:** the FIFO samples `data_in` / `data_in_valid` on the same edge. `word_out_valid` is asserted only when `fifo_full` is low, so no push is ever lost.
- **Combinational paths:** `byte_in_stall` and `word_out_valid` are combinational from `cnt`, `fifo_full` and `rst`. The byte source must sample `byte_in_stall` in the same cycle.
- **Registered outputs:** `byte_count` is the registered `cnt`. `err` is registered, one cycle after the violation.

## Test plan
1. **Basic pack:** reset, then bytes 0x01..0x08 on 8 consecutive cycles with `fifo_full` = 0.
   - Cycle 9: `word_out_valid` = 1 and `word_out` = 0x0102030405060708.
   - Next cycle: `byte_count` = 0.
2. **Back-to-back words:** 16 consecutive bytes 0x10..0x1F with `fifo_full` = 0.
   - Pushes 0x1011121314151617, then 0x18191A1B1C1D1E1F eight cycles later.
   - `byte_in_stall` never asserts.
3. **Back-pressure:** fill 8 bytes 0xA0..0xA7 while `fifo_full` = 1.
   - `byte_in_stall` = 1 and `word_out_valid` = 0.
   - Present 0xFF during the stall: `err` pulses once the next cycle and the word is unchanged.
   - Drop `fifo_full`: `word_out` = 0xA0A1A2A3A4A5A6A7 pushes that cycle.
4. **Flush:** bytes 0xDE, 0xAD, then `flush` together with byte 0xBE.
   - Next cycle: `word_out_valid` = 1 and `word_out` = 0xDEADBE0000000000.
   - `flush` at `byte_count` = 0 produces no push.
5. **Reset mid-word:** 5 bytes, then `rst` for 1 cycle.
   - `byte_count` = 0 and `word_out` = 0.
   - A following 0x01..0x08 sequence produces exactly 0x0102030405060708.
6. **Integration with `fifo`:** push 5 words with the FIFO never popped.
   - 4 words enter.
   - The 5th holds with `byte_in_stall` = 1 until one `pop_fifo`, after which it pushes the next cycle.

Source files
------------

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Packs a stream of 8-bit bytes, most-significant byte first,
//               into 64-bit words and pushes each complete word into a
//               downstream FIFO. Back-pressures the byte source while a
//               finished word is blocked. A flush closes a partial word with
//               zero padding.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    input  logic        flush,
    input  logic        fifo_full,
    output logic [63:0] word_out,
    output logic        word_out_valid,
    output logic        byte_in_stall,
    output logic [3:0]  byte_count,
    output logic        err
);

    // A word is complete once eight byte slots are accounted for, whether
    // by data or by flush padding.
    localparam logic [3:0] c_FULL_CNT = 4'd8;

    logic [63:0] r_word;
    logic [3:0]  r_cnt;
    logic        r_err;

    logic        w_complete;
    logic        w_accept;
    logic [63:0] w_base_word;
    logic [3:0]  w_base_cnt;
    logic [63:0] w_next_word;
    logic [3:0]  w_next_cnt;
    logic        w_next_err;

    // Handshake decode: push and stall both depend only on the held count,
    // the FIFO's full flag and reset, never on the incoming byte.
    always_comb begin
        w_complete     = (r_cnt == c_FULL_CNT);
        word_out_valid = w_complete && !fifo_full && !rst;
        byte_in_stall  = w_complete && fifo_full && !rst;
        w_accept       = byte_in_valid && !byte_in_stall;
    end

    // Next-state: a push empties the register first, so a byte arriving in
    // the same cycle becomes byte 0 of the next word without a bubble.
    always_comb begin
        w_base_word = word_out_valid ? 64'd0 : r_word;
        w_base_cnt  = word_out_valid ? 4'd0 : r_cnt;
        w_next_word = w_base_word;
        w_next_cnt  = w_base_cnt;

        if (w_accept) begin
            for (int i = 0; i < 8; i++) begin
                if (w_base_cnt == 4'(i)) begin
                    w_next_word[8*(7-i) +: 8] = byte_in;
                end
            end
            w_next_cnt = w_base_cnt + 4'd1;
        end

        // Flush only closes a word that holds some data but is not yet full;
        // the low bytes were cleared on the previous push, so they pad as 0.
        if (flush && (w_next_cnt != 4'd0) && (w_next_cnt != c_FULL_CNT)) begin
            w_next_cnt = c_FULL_CNT;
        end

        w_next_err = (byte_in_valid || flush) && byte_in_stall;
    end

    // State register: synchronous reset discards any partial or full word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= 64'd0;
            r_cnt  <= 4'd0;
            r_err  <= 1'b0;
        end else begin
            r_word <= w_next_word;
            r_cnt  <= w_next_cnt;
            r_err  <= w_next_err;
        end
    end

    // Registered state drives the remaining outputs directly.
    always_comb begin
        word_out   = r_word;
        byte_count = r_cnt;
        err        = r_err;
    end

endmodule
`default_nettype wire
